// File: rtl/multi_channel_counter_display_if.sv
// Button/display bus for multi_channel_counter_display.
// slave modport: the counter block (takes buttons and clears, drives the display and counts).
// master modport: whoever supplies buttons and watches the display pins.
interface multi_channel_counter_display_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0]   raw;        // asynchronous buttons, active-high
  logic [CHANNELS-1:0]   clear;      // per-channel synchronous clear, active-high
  logic [CHANNELS-1:0]   anode;      // digit enables, active-low
  logic [7:0]            seg;        // segments a..g on bits 0..6, dp on bit 7, active-low
  logic [4*CHANNELS-1:0] counts;     // channel i count on bits [4i+3:4i]
  logic [CHANNELS-1:0]   inc_pulse;  // one cycle per press-driven count update

  modport master (
    output raw, clear,
    input  anode, seg, counts, inc_pulse
  );

  modport slave (
    input  raw, clear,
    output anode, seg, counts, inc_pulse
  );
endinterface

// File: rtl/multi_channel_counter_display.sv
// N-channel debounced push-button tally, counts shown time-multiplexed on one 7-seg display.
// Latency: raw rise to count/inc_pulse DEBOUNCE_LIMIT+3 cycles; display follows sel/count by 1 cycle.
// No backpressure: presses are counted as they arrive; the display scan is free-running.
//
// Ports: sysclock (all logic on rising edge), reset (synchronous, active-high),
//        bus (slave modport: raw, clear in; anode, seg, counts, inc_pulse out).
// Optional build macro SCAN_BLANK_EN: blank the display for the first 1/8 of each digit
// slot (anti-ghosting); needs SCAN_BITS >= 3. Undefined: selected digit lit for the whole slot.
module multi_channel_counter_display #(
  parameter int CHANNELS       = 4,
  parameter int MODULUS        = 10,
  parameter int DEBOUNCE_LIMIT = 65535,
  parameter int SCAN_BITS      = 16
) (
  input  logic                             sysclock,
  input  logic                             reset,
  multi_channel_counter_display_if.slave   bus
);

  localparam int DCNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_LIMIT - 1);
  localparam logic [3:0]        CNT_MAX  = 4'(MODULUS - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX  = SEL_W'(CHANNELS - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [SCAN_BITS-1:0] BLANK_END = SCAN_BITS'(1) << (SCAN_BITS - 3);
`endif

  // Synchroniser, debouncer and counter state
  logic [CHANNELS-1:0] meta_q, sync_q;
  logic [CHANNELS-1:0] clean_q, clean_d;
  logic [CHANNELS-1:0] clean_dly_q;      // clean one cycle ago, for rising-edge detect
  logic [DCNT_W-1:0]   dcnt_q [CHANNELS];
  logic [DCNT_W-1:0]   dcnt_d [CHANNELS];
  logic [3:0]          cnt_q  [CHANNELS];
  logic [3:0]          cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] inc_q, inc_d;

  // Scan and display state
  logic [SCAN_BITS-1:0] presc_q, presc_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [CHANNELS-1:0]  anode_q, anode_d;
  logic [7:0]           seg_q, seg_d;

  // Active-low segment pattern, bit0 = a ... bit6 = g
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] p;
    case (digit)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Per-channel debounce and count next-state
  always_comb begin
    logic rise;
    rise    = 1'b0;
    clean_d = clean_q;
    dcnt_d  = dcnt_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    inc_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Any cycle where sync agrees with clean restarts the stability run
      if (sync_q[i] == clean_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DCNT_MAX) begin
        clean_d[i] = sync_q[i];
        dcnt_d[i]  = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
      end

      rise     = clean_q[i] & ~clean_dly_q[i];
      inc_d[i] = rise;
      if (rise) begin
        if (cnt_q[i] == CNT_MAX) begin
          cnt_d[i] = '0;
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
      // Clear overrides a same-cycle increment; the pulse still reports the press
      if (bus.clear[i]) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end
    end
  end

  // Scan prescaler, digit select and display pattern next-state
  always_comb begin
    presc_d = presc_q + SCAN_BITS'(1);
    sel_d   = sel_q;
    if (presc_q == '1) begin
      sel_d = (sel_q == SEL_MAX) ? '0 : sel_q + SEL_W'(1);
    end
    anode_d = ~(CHANNELS'(1) << sel_q);
    seg_d   = {~ovf_q[sel_q], seg_pattern(cnt_q[sel_q])};
`ifdef SCAN_BLANK_EN
    if (presc_q < BLANK_END) begin
      anode_d = '1;
      seg_d   = 8'hFF;
    end
`endif
  end

  always_ff @(posedge sysclock) begin
    if (reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      clean_q     <= '0;
      clean_dly_q <= '0;
      ovf_q       <= '0;
      inc_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        dcnt_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      presc_q <= '0;
      sel_q   <= '0;
      anode_q <= '1;
      seg_q   <= 8'hFF;
    end else begin
      meta_q      <= bus.raw;
      sync_q      <= meta_q;
      clean_q     <= clean_d;
      clean_dly_q <= clean_q;
      ovf_q       <= ovf_d;
      inc_q       <= inc_d;
      dcnt_q      <= dcnt_d;
      cnt_q       <= cnt_d;
      presc_q     <= presc_d;
      sel_q       <= sel_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
    end
  end

  always_comb begin
    bus.counts = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.counts[4*i +: 4] = cnt_q[i];
    end
  end

  assign bus.anode     = anode_q;
  assign bus.seg       = seg_q;
  assign bus.inc_pulse = inc_q;

endmodule

// File: doc/multi_channel_counter_display.md
# multi_channel_counter_display

Parametrised N-channel tally block: each push-button input is synchronised, debounced and counted modulo a configurable base, and the per-channel digits are time-multiplexed onto one active-low seven-segment display. It supersedes the fixed four-button mod-10 display, adding configurable width and depth, per-channel clear, overflow indication on the decimal point, a count observation bus and fully synchronous operation. It sits between the board buttons and switches and the display pins.

## Interface
- CHANNELS, 4: number of button/digit channels, 1..8.
- MODULUS, 10: counter base, 2..10; each count runs 0..MODULUS-1.
- DEBOUNCE_LIMIT, 65535: consecutive stable cycles needed before the debounced level changes, ≥2.
- SCAN_BITS, 16: scan prescaler width; each digit is held for 2^SCAN_BITS cycles.

- sysclock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- raw  in  CHANNELS  asynchronous button inputs, active-high.
- clear  in  CHANNELS  synchronous per-channel clear, active-high, level-sensitive.
- anode  out  CHANNELS  digit enables, active-low, registered.
- seg  out  8  segments, active-low, registered; bit0=a … bit6=g, bit7=dp.
- counts  out  4*CHANNELS  channel i count on bits [4i+3:4i], registered.
- inc_pulse  out  CHANNELS  one-cycle pulse on the cycle a channel's count updates from a press.

## Operation
- Synchroniser: 2 flops per raw bit; sync[i] is raw[i] delayed 2 cycles.
- Debouncer per channel: clean[i] and a counter dcnt[i] of width clog2(DEBOUNCE_LIMIT).
  - If sync == clean: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_LIMIT-1: clean <= sync, dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Net effect: clean follows sync only after DEBOUNCE_LIMIT consecutive differing cycles. Any glitch shorter than that restarts the count.
- Counter per channel: a rising edge of clean (registered clean_d vs clean) increments count.
  - Wraps from MODULUS-1 to 0. On wrap, ovf[i] <= 1 (sticky).
  - inc_pulse[i] asserts in the same cycle count updates.
  - Falling edges of clean are ignored.
- clear[i]: count <= 0, ovf <= 0. The debouncer is unaffected.
- Scan: prescaler counts 0..2^SCAN_BITS-1, free-running. On all-ones, sel advances; sel wraps from CHANNELS-1 to 0.
- Display registers, updated every cycle:
  - anode <= ~(1 << sel).
  - seg[6:0] <= active-low pattern of count[sel], standard digits 0–9.
  - seg[7] <= ~ovf[sel] (dp lit when that channel has wrapped).
- Reset: sync, clean, clean_d, dcnt, counts, ovf, prescaler and sel go to 0. anode = all-ones, seg = 8'hFF, inc_pulse = 0. The first display update occurs on the first cycle after reset deasserts.

## Timing
- raw rise to clean rise: 2 + DEBOUNCE_LIMIT cycles, when raw is held stable.
- clean rise to count/inc_pulse: 1 cycle. Total raw-to-count latency: DEBOUNCE_LIMIT + 3 cycles.
- counts output: same cycle as the internal count register (it is that register).
- Display: anode/seg reflect sel and count one cycle after they change.
- Digit period: 2^SCAN_BITS cycles; full frame: CHANNELS * 2^SCAN_BITS cycles.
- Simultaneous clear[i] and increment: clear wins; count=0, ovf=0, inc_pulse[i] still asserts.
- Reset asserted mid-debounce: in-progress stable counts are discarded; a held button after reset needs the full latency again.
- Channels are independent; simultaneous presses on all channels each count once.

## Configuration
- SCAN_BLANK_EN defined:
  - anode is forced to all-ones and seg to 8'hFF whenever prescaler < 2^(SCAN_BITS-3), the first 1/8 of each digit slot. This is the anti-ghosting blanking interval.
  - Requires SCAN_BITS ≥ 3.
- Not defined: no blanking; the selected anode is low for the whole slot.

## Test plan
Parameters: CHANNELS=4, MODULUS=10, DEBOUNCE_LIMIT=4, SCAN_BITS=3.
- Clean press: raw[0] high for 20 cycles -> inc_pulse[0] exactly once, 7 cycles after the raw rise; counts[3:0]=1; other channels stay 0.
- Bounce: raw[1] toggles with 3-cycle high and 3-cycle low periods, 10 times, then held high -> exactly one increment on channel 1, 7 cycles after the final rise.
- Wrap/overflow: 10 clean presses on channel 2 -> counts[11:8]=0. While sel=2: seg[7]=0 and seg[6:0]=7'b1000000. Then clear[2] -> seg[7]=1.
- Clear collision: clear[3] asserted in the same cycle as channel 3's increment -> counts[15:12]=0, inc_pulse[3]=1.
- Scan sequence: after reset, anode steps 1110, 1101, 1011, 0111, each held 8 cycles, then repeats. With counts 1,2,3,4 loaded, seg[6:0] = 1111001, 0100100, 0110000, 0011001 in matching slots.
- Reset mid-operation: reset for 1 cycle during a debounce in progress and with count=5 -> all counts 0, anode=1111 and seg=8'hFF during reset; a held button increments after a full 7 cycles. With SCAN_BLANK_EN: anode=1111 for cycle 0 of every 8-cycle slot.
